// File: rtl/lspc_timer_unit_if.sv
// LSPC timer unit register bus.
// One-cycle write strobe with combinational readback.
interface lspc_timer_unit_if;
    logic        WR;
    logic [3:0]  ADDR;
    logic [15:0] WDATA;
    logic [15:0] RDATA;

    modport master (
        output WR,
        output ADDR,
        output WDATA,
        input  RDATA
    );

    modport slave (
        input  WR,
        input  ADDR,
        input  WDATA,
        output RDATA
    );
endinterface

// File: rtl/lspc_timer_unit.sv
// LSPC raster/pixel timer unit.
// Per-channel down-counters clocked by a 6 MHz pixel enable.
module lspc_timer_unit #(
    parameter int CHANNELS   = 2,
    parameter int TIMER_W    = 32,
    parameter int VIDEO_MODE = 1
) (
    input  logic                CLK_24M,
    input  logic                nRESET,
    lspc_timer_unit_if.slave    bus,
    input  logic [8:0]          VCOUNT,
    input  logic                VBL_START,
    output logic [CHANNELS-1:0] nIRQ,
    output logic                nIRQ_ANY,
    output logic                PIX_TICK
);
    localparam int HI_W = TIMER_W - 16;
    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);
    localparam logic PAL = (VIDEO_MODE != 0);

    logic [1:0]  div_q;
    logic        in_border;
    logic [15:0] rd_ch [CHANNELS];
    logic [15:0] rdata;
    logic        unused_vcount_lo;

    assign unused_vcount_lo = ^VCOUNT[3:0];

    // Free-running divide-by-four pixel enable
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 2'd1;
        end
    end

    assign PIX_TICK  = (div_q == 2'd3);
    assign in_border = (VCOUNT[7:4] == 4'h0) || (VCOUNT[7:4] == 4'hF);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [TIMER_W-1:0] count_q;
        logic [TIMER_W-1:0] reload_q;
        logic [4:0]         ctrl_q;
        logic               pending_q;
        logic               nirq_q;
        logic               sel;
        logic               wr_hi;
        logic               wr_lo;
        logic               wr_ctl;
        logic               wr_ack;
        logic               running;
        logic               zero_tick;
        logic               set_pend;
        logic [31:0]        cnt_w;
        logic [15:0]        rd;

        assign sel    = bus.WR && (bus.ADDR[3:2] == 2'(c));
        assign wr_hi  = sel && (bus.ADDR[1:0] == 2'd0);
        assign wr_lo  = sel && (bus.ADDR[1:0] == 2'd1);
        assign wr_ctl = sel && (bus.ADDR[1:0] == 2'd2);
        assign wr_ack = sel && (bus.ADDR[1:0] == 2'd3);

        assign running   = VCOUNT[8] && !(PAL && ctrl_q[4] && in_border);
        assign zero_tick = PIX_TICK && running && (count_q == '0);
        assign set_pend  = zero_tick && ctrl_q[3];

        // Reload halves and control written from the bus
        always_ff @(posedge CLK_24M or negedge nRESET) begin
            if (!nRESET) begin
                reload_q <= '0;
                ctrl_q   <= '0;
            end else begin
                unique case (1'b1)
                    wr_hi:   reload_q[TIMER_W-1:16] <= bus.WDATA[HI_W-1:0];
                    wr_lo:   reload_q[15:0] <= bus.WDATA;
                    wr_ctl:  ctrl_q <= bus.WDATA[4:0];
                    default: ;
                endcase
            end
        end

        // Counter: bus load beats VBL load beats tick
        always_ff @(posedge CLK_24M or negedge nRESET) begin
            if (!nRESET) begin
                count_q <= '0;
            end else if (wr_lo && ctrl_q[0]) begin
                count_q <= {reload_q[TIMER_W-1:16], bus.WDATA};
            end else if (VBL_START && ctrl_q[1]) begin
                count_q <= reload_q;
            end else if (PIX_TICK && running) begin
                if (count_q != '0) begin
                    count_q <= count_q - ONE;
                end else if (ctrl_q[2]) begin
                    count_q <= reload_q;
                end
            end
        end

        // Pending flag; a new zero tick wins over an ack
        always_ff @(posedge CLK_24M or negedge nRESET) begin
            if (!nRESET) begin
                pending_q <= 1'b0;
                nirq_q    <= 1'b1;
            end else begin
                if (set_pend) begin
                    pending_q <= 1'b1;
                end else if (wr_ack && bus.WDATA[0]) begin
                    pending_q <= 1'b0;
                end
                nirq_q <= ~pending_q;
            end
        end

        assign cnt_w = 32'(count_q);

        // Register readback for this channel
        always_comb begin
            rd = '0;
            unique case (bus.ADDR[1:0])
                2'd0: rd = cnt_w[31:16];
                2'd1: rd = cnt_w[15:0];
                2'd2: rd = {11'b0, ctrl_q};
                2'd3: rd = {15'b0, pending_q};
            endcase
        end

        assign rd_ch[c] = rd;
        assign nIRQ[c]  = nirq_q;
    end

    // Channel select for readback; absent channels read zero
    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.ADDR[3:2] == 2'(c)) begin
                rdata = rd_ch[c];
            end
        end
    end

    assign bus.RDATA = rdata;
    assign nIRQ_ANY  = &nIRQ;
endmodule

// File: tb/tb_lspc_timer_unit.sv
// Bench for lspc_timer_unit: two configurations driven in lockstep,
// a behavioural model feeding a scoreboard, and a monitor that compares.
module tb_lspc_timer_unit;
    localparam int NI = 2;

    typedef struct {
        logic [3:0]  nirq;
        logic        any;
        logic        pix;
        logic [15:0] rd;
    } exp_t;

    int chs [NI] = '{2, 3};
    int tw  [NI] = '{32, 20};
    int vm  [NI] = '{1, 0};

    logic        CLK_24M = 1'b0;
    logic        nRESET = 1'b0;
    logic [8:0]  VCOUNT = '0;
    logic        VBL_START = 1'b0;
    logic        WR = 1'b0;
    logic [3:0]  ADDR = '0;
    logic [15:0] WDATA = '0;

    logic [1:0] nirq0;
    logic [2:0] nirq1;
    logic       any0, any1, pix0, pix1;

    longint unsigned m_cnt [NI][4];
    longint unsigned m_rel [NI][4];
    logic [4:0]      m_ctl [NI][4];
    bit              m_pend [NI][4];
    bit              m_irqn [NI][4];
    int unsigned     cyc;

    exp_t sbq [NI][$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    lspc_timer_unit_if bus0 ();
    lspc_timer_unit_if bus1 ();

    assign bus0.WR = WR;
    assign bus0.ADDR = ADDR;
    assign bus0.WDATA = WDATA;
    assign bus1.WR = WR;
    assign bus1.ADDR = ADDR;
    assign bus1.WDATA = WDATA;

    lspc_timer_unit #(.CHANNELS(2), .TIMER_W(32), .VIDEO_MODE(1)) u0 (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .bus(bus0),
        .VCOUNT(VCOUNT), .VBL_START(VBL_START),
        .nIRQ(nirq0), .nIRQ_ANY(any0), .PIX_TICK(pix0)
    );

    lspc_timer_unit #(.CHANNELS(3), .TIMER_W(20), .VIDEO_MODE(0)) u1 (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .bus(bus1),
        .VCOUNT(VCOUNT), .VBL_START(VBL_START),
        .nIRQ(nirq1), .nIRQ_ANY(any1), .PIX_TICK(pix1)
    );

    always #5 CLK_24M = ~CLK_24M;

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                m_cnt[i][ch] = 0;
                m_rel[i][ch] = 0;
                m_ctl[i][ch] = '0;
                m_pend[i][ch] = 0;
                m_irqn[i][ch] = 1;
            end
        end
        cyc = 0;
    endfunction

    function automatic void model_edge();
        bit tick;
        tick = (cyc % 4 == 3);
        if (!nRESET) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            longint unsigned mask;
            mask = (64'd1 << tw[i]) - 1;
            for (int ch = 0; ch < chs[i]; ch++) begin
                longint unsigned nc;
                bit np, run, sel, setp;
                int nib;
                nib = int'(VCOUNT[7:4]);
                run = (VCOUNT >= 9'd256) &&
                      !(vm[i] == 1 && m_ctl[i][ch][4] && (nib == 0 || nib == 15));
                sel = WR && (int'(ADDR[3:2]) == ch);
                nc = m_cnt[i][ch];
                np = m_pend[i][ch];
                setp = 0;
                m_irqn[i][ch] = !m_pend[i][ch];
                if (tick && run) begin
                    if (nc != 0) begin
                        nc = nc - 1;
                    end else begin
                        setp = m_ctl[i][ch][3];
                        if (m_ctl[i][ch][2]) nc = m_rel[i][ch];
                    end
                end
                if (VBL_START && m_ctl[i][ch][1]) nc = m_rel[i][ch];
                if (sel && ADDR[1:0] == 2'd1 && m_ctl[i][ch][0])
                    nc = ((m_rel[i][ch] >> 16) << 16) | longint'(WDATA);
                if (setp) np = 1;
                else if (sel && ADDR[1:0] == 2'd3 && WDATA[0]) np = 0;
                if (sel) begin
                    case (ADDR[1:0])
                        2'd0: m_rel[i][ch] = ((longint'(WDATA) << 16) |
                                              (m_rel[i][ch] & 64'hFFFF)) & mask;
                        2'd1: m_rel[i][ch] = (m_rel[i][ch] & ~64'hFFFF) |
                                             longint'(WDATA);
                        2'd2: m_ctl[i][ch] = WDATA[4:0];
                        default: ;
                    endcase
                end
                m_cnt[i][ch] = nc & mask;
                m_pend[i][ch] = np;
            end
        end
        cyc++;
    endfunction

    function automatic exp_t expect_now(int i);
        exp_t x;
        int ch;
        x.nirq = 4'hF;
        for (int c = 0; c < chs[i]; c++) x.nirq[c] = m_irqn[i][c];
        x.any = &x.nirq;
        x.pix = (cyc % 4 == 3);
        ch = int'(ADDR[3:2]);
        x.rd = '0;
        if (ch < chs[i]) begin
            case (ADDR[1:0])
                2'd0: x.rd = 16'(m_cnt[i][ch] >> 16);
                2'd1: x.rd = 16'(m_cnt[i][ch]);
                2'd2: x.rd = {11'b0, m_ctl[i][ch]};
                default: x.rd = {15'b0, m_pend[i][ch]};
            endcase
        end
        return x;
    endfunction

    // Reference model steps with the clock and queues what the DUTs must show
    always @(posedge CLK_24M) begin
        model_edge();
        for (int i = 0; i < NI; i++) sbq[i].push_back(expect_now(i));
    end

    task automatic chk(string nm, int i, logic [15:0] got, logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, i, $time, got, want);
        end
    endtask

    task automatic compare_one(int i, exp_t x);
        logic [3:0] an;
        an = (i == 0) ? {2'b11, nirq0} : {1'b1, nirq1};
        chk("nIRQ", i, 16'(an), 16'(x.nirq));
        chk("nIRQ_ANY", i, 16'((i == 0) ? any0 : any1), 16'(x.any));
        chk("PIX_TICK", i, 16'((i == 0) ? pix0 : pix1), 16'(x.pix));
        chk("RDATA", i, (i == 0) ? bus0.RDATA : bus1.RDATA, x.rd);
    endtask

    // Monitor: pop and compare shortly after each edge
    always @(posedge CLK_24M) begin
        #2;
        for (int i = 0; i < NI; i++) begin
            while (sbq[i].size() > 0) begin
                e = sbq[i].pop_front();
                compare_one(i, e);
            end
        end
    end

    task automatic cyc_in(bit w, logic [3:0] a, logic [15:0] d, bit v);
        @(negedge CLK_24M);
        WR = w;
        ADDR = a;
        WDATA = d;
        VBL_START = v;
    endtask

    task automatic idle(int n, logic [3:0] a);
        repeat (n) cyc_in(1'b0, a, 16'h0, 1'b0);
    endtask

    task automatic wr(logic [3:0] a, logic [15:0] d);
        cyc_in(1'b1, a, d, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK_24M);
        nRESET = 1'b0;
        WR = 1'b0;
        VBL_START = 1'b0;
        ADDR = 4'h3;
        repeat (3) @(negedge CLK_24M);
        nRESET = 1'b1;
    endtask

    // Drive an action so the following edge is a pixel tick
    // (and, if want_zero, a tick where channel 0 sits at zero)
    task automatic act_on_tick(bit w, logic [3:0] a, logic [15:0] d,
                               bit v, bit want_zero);
        bit done;
        done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge CLK_24M);
            if (cyc % 4 == 3 && (!want_zero || m_cnt[0][0] == 0)) begin
                WR = w;
                ADDR = a;
                WDATA = d;
                VBL_START = v;
                done = 1;
            end else begin
                WR = 1'b0;
                VBL_START = 1'b0;
            end
        end
        if (!done) begin
            $display("FAIL tick_align: no aligned cycle within 64, want one");
            $fatal(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] ra;
        logic [15:0] rd;
        model_reset();
        ADDR = 4'h3;
        repeat (3) @(negedge CLK_24M);
        nRESET = 1'b1;

        VCOUNT = 9'h120;
        wr(4'h2, 16'h000D);
        wr(4'h0, 16'h0000);
        wr(4'h1, 16'h0003);
        idle(40, 4'h1);
        idle(4, 4'h3);

        wr(4'h3, 16'h0001);
        act_on_tick(1'b1, 4'h3, 16'h0001, 1'b0, 1'b1);
        idle(3, 4'h3);
        wr(4'h3, 16'h0001);
        idle(4, 4'h3);

        do_reset();
        VCOUNT = 9'h120;
        wr(4'h6, 16'h0008);
        idle(12, 4'h7);
        idle(2, 4'h3);

        do_reset();
        VCOUNT = 9'h120;
        wr(4'h2, 16'h0003);
        wr(4'h0, 16'h0000);
        wr(4'h1, 16'h0050);
        idle(5, 4'h1);
        act_on_tick(1'b1, 4'h1, 16'h0010, 1'b1, 1'b0);
        idle(6, 4'h1);

        wr(4'h2, 16'h0001);
        wr(4'h1, 16'h0040);
        VCOUNT = 9'h0F8;
        idle(400, 4'h1);

        do_reset();
        wr(4'h2, 16'h0011);
        wr(4'h1, 16'h0100);
        VCOUNT = 9'h1F5;
        idle(40, 4'h1);
        VCOUNT = 9'h150;
        idle(40, 4'h1);
        VCOUNT = 9'h105;
        idle(20, 4'h1);

        wr(4'h0, 16'hFFFF);
        wr(4'h1, 16'h1234);
        idle(3, 4'h0);

        wr(4'hA, 16'h0005);
        wr(4'hD, 16'hFFFF);
        wr(4'hE, 16'h0001);
        idle(2, 4'hA);
        idle(2, 4'hE);
        idle(2, 4'hF);

        VCOUNT = 9'h120;
        wr(4'h2, 16'h000D);
        wr(4'h1, 16'h0020);
        idle(10, 4'h1);
        @(negedge CLK_24M);
        nRESET = 1'b0;
        repeat (2) @(negedge CLK_24M);
        nRESET = 1'b1;
        idle(12, 4'h1);

        for (int n = 0; n < 3000; n++) begin
            ra = 4'($urandom);
            rd = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 8))
                                             : 16'($urandom);
            cyc_in($urandom_range(0, 3) == 0, ra, rd,
                   $urandom_range(0, 31) == 0);
            nRESET = ($urandom_range(0, 499) != 0);
            if (n % 64 == 0) begin
                VCOUNT = ($urandom_range(0, 3) == 0) ? 9'($urandom)
                                                     : {1'b1, 8'($urandom)};
            end
        end

        nRESET = 1'b1;
        idle(4, 4'h3);
        repeat (2) @(negedge CLK_24M);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lspc_timer_unit.md
LSPC_TIMER_UNIT -- requirements
Module: lspc_timer_unit

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent raster/pixel timers (1..4).
REQ-002 SHALL have parameter TIMER_W, default 32: counter and reload width (17..32).
REQ-003 SHALL have parameter VIDEO_MODE, default 1: 1 = PAL (border stop allowed), 0 = NTSC (border stop ignored).
REQ-004 SHALL have port CLK_24M  input  1  master clock; all state changes on its rising edge.
REQ-005 SHALL have port nRESET  input  1  asynchronous active-low reset.
REQ-006 SHALL have port WR  input  1  single-cycle register write strobe.
REQ-007 SHALL have port ADDR  input  4  register select, {channel[1:0], reg[1:0]}.
REQ-008 SHALL have port WDATA  input  16  write data.
REQ-009 SHALL have port RDATA  output  16  combinational readback of the addressed register.
REQ-010 SHALL have port VCOUNT  input  9  current raster line.
REQ-011 SHALL have port VBL_START  input  1  single-cycle pulse at vblank entry.
REQ-012 SHALL have port nIRQ  output  CHANNELS  per-channel pending interrupt, active-low.
REQ-013 SHALL have port nIRQ_ANY  output  1  AND of all nIRQ bits.
REQ-014 SHALL have port PIX_TICK  output  1  internal 6 MHz enable, high one cycle in four.

Function
REQ-015 SHALL generate PIX_TICK from a free-running 2-bit divider; high when the divider equals 3.
REQ-016 SHALL decode per channel: reg0 = RELOAD[TIMER_W-1:16], reg1 = RELOAD[15:0], reg2 = CTRL[4:0], reg3 = ACK.
REQ-017 SHALL define CTRL bits: bit0 load-on-reg1-write, bit1 load-at-VBL_START, bit2 auto-reload-at-zero, bit3 IRQ enable, bit4 border stop.
REQ-018 SHALL ignore writes to channel indices >= CHANNELS; reads from them SHALL return 0.
REQ-019 SHALL return on reads: reg0/reg1 = live COUNT high/low, reg2 = {11'b0, CTRL}, reg3 = {15'b0, pending}.
REQ-020 SHALL mark a channel running when VCOUNT[8] = 1 and not (VIDEO_MODE & CTRL[4] & (VCOUNT[7:4] = 0 or VCOUNT[7:4] = 4'hF)).
REQ-021 SHALL, on PIX_TICK while running with COUNT != 0, decrement COUNT by 1.
REQ-022 SHALL, on PIX_TICK while running with COUNT = 0, set pending if CTRL[3] = 1, and load COUNT = RELOAD if CTRL[2] = 1, otherwise hold COUNT at 0.
REQ-023 SHALL, when reg1 is written with CTRL[0] = 1, load COUNT with {RELOAD[hi], WDATA} in the same cycle.
REQ-024 SHALL, on VBL_START with CTRL[1] = 1, load COUNT = RELOAD regardless of the running state.
REQ-025 SHALL use this COUNT priority within one cycle: register-write load > VBL_START load > tick decrement/reload.
REQ-026 SHALL clear pending on a reg3 write with WDATA[0] = 1; a pending set in the same cycle SHALL take priority over the ack.
REQ-027 SHALL NOT set pending on any tick where CTRL[3] = 0; clearing CTRL[3] SHALL NOT clear an already pending flag.
REQ-028 SHALL drive nIRQ[i] = ~pending[i] registered, so assertion appears one cycle after the zero tick.
REQ-029 SHALL keep all arithmetic modulo 2^TIMER_W; RELOAD bits above TIMER_W-1 SHALL be discarded.

Reset
REQ-030 SHALL, while nRESET = 0, force COUNT = 0, RELOAD = 0, CTRL = 0, pending = 0, and divider = 0.
REQ-031 SHALL hold nIRQ all-ones, nIRQ_ANY = 1, PIX_TICK = 0, and RDATA = 0 for reg3 during reset.
REQ-032 SHALL abandon any in-progress count when reset asserts mid-operation; the first PIX_TICK after release SHALL occur on the 4th rising edge.

Verification
REQ-033 SHALL verify a countdown: with CTRL = 0x0D, RELOAD = 3, VCOUNT = 0x120, and a reg1 write -> nIRQ[0] goes low 1 cycle after the 4th PIX_TICK and COUNT reloads to 3.
REQ-034 SHALL verify the border stop: with VIDEO_MODE = 1, CTRL[4] = 1, and VCOUNT = 0x1F5 -> COUNT frozen; at VCOUNT = 0x150 -> COUNT decrements; with VIDEO_MODE = 0 -> COUNT decrements at 0x1F5.
REQ-035 SHALL verify no running below line 0x100: VCOUNT = 0x0F8 for 100 ticks -> COUNT unchanged.
REQ-036 SHALL verify an ack collision: ack written on the same cycle as a zero tick with CTRL[3] = 1 -> pending remains 1; a later ack -> nIRQ high the next cycle.
REQ-037 SHALL verify load priority: a reg1 write (CTRL[0] = 1, WDATA = 0x0010) coincident with VBL_START (RELOAD = 0x50) and a tick -> COUNT = 0x0010.
REQ-038 SHALL verify channel independence: channel 1 at CTRL = 0x08, RELOAD = 0, while channel 0 is idle -> only nIRQ[1] goes low and nIRQ_ANY goes low.
